// File: rtl/sqrt_error_monitor.sv
// rtl/sqrt_error_monitor.sv - exhaustive radicand sweep with ER/NMED/EDmax raw counters
// Reference root is tracked incrementally: s = floor(sqrt(R_out)), nsq = (s+1)^2.
module sqrt_error_monitor #(
    parameter int DUT_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] R_out,
    input  logic [7:0]  q_in,
    output logic        busy,
    output logic        done,
    output logic [16:0] error_count,
    output logic [23:0] ed_sum,
    output logic [7:0]  ed_max
);
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_idx;
    logic [15:0] r_rout;
    logic        r_rvalid;
    logic [7:0]  r_s;
    logic [16:0] r_nsq;
    logic        r_busy;
    logic [16:0] r_err;
    logic [23:0] r_sum;
    logic [7:0]  r_max;
    logic        w_accept;
    logic        w_busy_next;
    logic        w_done;
    logic        w_hit;
    logic [7:0]  w_ref;
    logic [7:0]  w_ref_d;
    logic        w_valid_d;
    logic [7:0]  w_ed;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_hit    = ({1'b0, r_rout} == r_nsq);
    assign w_ref    = w_hit ? r_s + 8'd1 : r_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_SWEEP;
            S_SWEEP:        if (r_idx == 17'd65535) w_next = S_DRAIN;
            S_DRAIN:        if (r_idx == 17'(DUT_LAT)) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    // busy is registered so it rises one edge after the start edge, aligned with R_out = 0
    always_comb begin
        w_done      = (r_state == S_DONE);
        w_busy_next = (r_state == S_SWEEP) || (r_state == S_DRAIN && w_next == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_rout   <= '0;
            r_rvalid <= 1'b0;
            r_s      <= '0;
            r_nsq    <= 17'd1;
            r_busy   <= 1'b0;
            r_err    <= '0;
            r_sum    <= '0;
            r_max    <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_accept) begin
                r_idx    <= '0;
                r_rout   <= '0;
                r_rvalid <= 1'b0;
                r_s      <= '0;
                r_nsq    <= 17'd1;
                r_err    <= '0;
                r_sum    <= '0;
                r_max    <= '0;
            end else begin
                case (r_state)
                    S_SWEEP: begin
                        r_rout   <= r_idx[15:0];
                        r_rvalid <= 1'b1;
                        r_idx    <= (r_idx == 17'd65535) ? 17'd0 : r_idx + 17'd1;
                    end
                    S_DRAIN: begin
                        r_rvalid <= 1'b0;
                        r_idx    <= r_idx + 17'd1;
                    end
                    default: r_rvalid <= 1'b0;
                endcase
                if (r_rvalid && w_hit) begin
                    r_s   <= r_s + 8'd1;
                    r_nsq <= r_nsq + {8'd0, r_s, 1'b0} + 17'd3;
                end
                if (w_valid_d) begin
                    r_err <= r_err + 17'(w_ed != 8'd0);
                    r_sum <= r_sum + {16'd0, w_ed};
                    if (w_ed > r_max) r_max <= w_ed;
                end
            end
        end
    end

    generate
        if (DUT_LAT == 0) begin : g_nodelay
            assign w_ref_d   = w_ref;
            assign w_valid_d = r_rvalid;
        end else begin : g_delay
            logic [7:0]         r_dl_ref [DUT_LAT];
            logic [DUT_LAT-1:0] r_dl_valid;

            always_ff @(posedge clk) begin
                if (rst || w_accept) begin
                    r_dl_valid <= '0;
                end else begin
                    r_dl_valid[0] <= r_rvalid;
                    for (int i = 1; i < DUT_LAT; i++) r_dl_valid[i] <= r_dl_valid[i-1];
                end
                r_dl_ref[0] <= w_ref;
                for (int i = 1; i < DUT_LAT; i++) r_dl_ref[i] <= r_dl_ref[i-1];
            end

            assign w_ref_d   = r_dl_ref[DUT_LAT-1];
            assign w_valid_d = r_dl_valid[DUT_LAT-1];
        end
    endgenerate

    assign w_ed = (w_ref_d >= q_in) ? w_ref_d - q_in : q_in - w_ref_d;

    assign R_out       = r_rout;
    assign busy        = r_busy;
    assign done        = w_done;
    assign error_count = r_err;
    assign ed_sum      = r_sum;
    assign ed_max      = r_max;
endmodule

// File: tb/tb_sqrt_error_monitor.sv
// tb/tb_sqrt_error_monitor.sv - six monitors in lock-step against exact, zero, +1, piped, random and mismatched roots
module tb_sqrt_error_monitor;
    localparam int N = 6;
    localparam int LATS [N] = '{0, 0, 0, 3, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ro [N];
    logic [7:0]  qv [N];
    logic        bz [N];
    logic        dn [N];
    logic [16:0] ec [N];
    logic [23:0] es [N];
    logic [7:0]  em [N];
    logic [7:0]  q_rnd = 8'd0;
    logic [7:0]  p3 [3];
    logic [7:0]  p5 [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int e0 [N];
    int m_ec [N];
    int m_sum [N];
    int m_max [N];

    function automatic int isqrt(input int r);
        int k = 0;
        for (int b = 7; b >= 0; b--) begin
            if (((k | (1 << b)) * (k | (1 << b))) <= r) k = k | (1 << b);
        end
        return k;
    endfunction

    function automatic int qmodel(input int i, input int r);
        if (i == 1) return 0;
        if (i == 2) return (isqrt(r) == 255) ? 255 : isqrt(r) + 1;
        return isqrt(r);
    endfunction

    assign qv[0] = 8'(isqrt(int'(ro[0])));
    assign qv[1] = 8'd0;
    assign qv[2] = 8'(qmodel(2, int'(ro[2])));
    assign qv[3] = p3[2];
    assign qv[4] = q_rnd;
    assign qv[5] = p5[2];

    always @(posedge clk) begin
        p3[0] <= 8'(isqrt(int'(ro[3])));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p5[0] <= 8'(isqrt(int'(ro[5])));
        p5[1] <= p5[0];
        p5[2] <= p5[1];
    end

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            sqrt_error_monitor #(.DUT_LAT(LATS[g])) u_dut (
                .clk(clk), .rst(rst), .start(start), .R_out(ro[g]), .q_in(qv[g]),
                .busy(bz[g]), .done(dn[g]), .error_count(ec[g]), .ed_sum(es[g]), .ed_max(em[g])
            );
        end
    endgenerate

    // Model: sample r is consumed at edge E0+2+r+L; a start is taken only when idle or done.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                e0[i] = -1; m_ec[i] = 0; m_sum[i] = 0; m_max[i] = 0;
            end else if (start && (e0[i] < 0 || cyc - e0[i] >= 65538 + LATS[i])) begin
                e0[i] = cyc; m_ec[i] = 0; m_sum[i] = 0; m_max[i] = 0;
            end else if (e0[i] >= 0) begin
                int n, r, q, d;
                n = cyc - e0[i];
                if (n >= 2 + LATS[i] && n <= 65537 + LATS[i]) begin
                    r = n - 2 - LATS[i];
                    q = (i == 4) ? int'(q_rnd) : qmodel(i, r);
                    d = (isqrt(r) > q) ? isqrt(r) - q : q - isqrt(r);
                    if (d != 0) m_ec[i]++;
                    m_sum[i] += d;
                    if (d > m_max[i]) m_max[i] = d;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            int n, x_ro, L;
            bit x_busy, x_done, ro_care, bad;
            L = LATS[i];
            if (e0[i] < 0) begin
                x_ro = 0; ro_care = 1; x_busy = 0; x_done = 0;
            end else begin
                n = cyc - e0[i];
                x_ro = (n == 0) ? 0 : n - 1;
                ro_care = (n <= 65536);
                x_busy = (n >= 1 && n <= 65536 + L);
                x_done = (n >= 65537 + L);
            end
            bad = (bz[i] != x_busy) || (dn[i] != x_done) || (ro_care && int'(ro[i]) != x_ro);
            if (i < 5) bad = bad || int'(ec[i]) != m_ec[i] || int'(es[i]) != m_sum[i] || int'(em[i]) != m_max[i];
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cmp u%0d cyc %0d: got ro=%0d busy=%0b done=%0b ec=%0d sum=%0d max=%0d, want ro=%0d busy=%0b done=%0b ec=%0d sum=%0d max=%0d",
                         i, cyc, ro[i], bz[i], dn[i], ec[i], es[i], em[i], x_ro, x_busy, x_done, m_ec[i], m_sum[i], m_max[i]);
            end
        end
        q_rnd = ($urandom_range(0, 3) == 0) ? 8'(isqrt(int'(ro[4]))) : 8'($urandom_range(0, 255));
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            e0[i] = -1; m_ec[i] = 0; m_sum[i] = 0; m_max[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        pulse_start();
        repeat (1001) @(negedge clk);
        chk("abort_rout_pre", ro[0], 1000);
        chk("abort_ec_pre", ec[1], 999);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rout", ro[0], 0);
        chk("abort_ec", ec[1], 0);
        chk("abort_sum", es[1], 0);
        chk("abort_busy", bz[1], 0);

        pulse_start();
        repeat (499) @(negedge clk);
        pulse_start();
        repeat (65036) @(negedge clk);
        pulse_start();
        repeat (8) @(negedge clk);

        chk("exact_ec", ec[0], 0);
        chk("exact_sum", es[0], 0);
        chk("zero_ec", ec[1], 65535);
        chk("zero_sum", es[1], 11152000);
        chk("zero_max", em[1], 255);
        chk("plus1_ec", ec[2], 65025);
        chk("plus1_sum", es[2], 65025);
        chk("plus1_max", em[2], 1);
        chk("pipe3_ec", ec[3], 0);
        chk("pipe3_done", dn[3], 1);
        chk("latmismatch_nonzero", ec[5] != 0, 1);
        chk("model_zero_sum", m_sum[1], 11152000);
        chk("model_plus1_ec", m_ec[2], 65025);

        pulse_start();
        chk("restart_ec", ec[1], 0);
        chk("restart_done", dn[1], 0);
        repeat (300) @(negedge clk);
        chk("restart_rout", ro[1], 299);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_error_monitor.md
# sqrt_error_monitor

On-chip error-metrics engine for the approximate square-root units (16-bit radicand, 8-bit root). It sweeps the radicand exhaustively from 0 to 65535 into a DUT and derives the exact reference root incrementally, without a multiplier or a square root. It accumulates the raw counters behind ER, NMED and EDmax, and the host normalises them. It sits beside any approximate square-root variant and replaces simulation-only metric runs on FPGA.

## Interface
- DUT_LAT, default 0: pipeline latency of the attached DUT in clocks, from R_out to q_in. 0 means the DUT is combinational.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE or DONE
- R_out  out  16  radicand driven to the DUT R input; registered
- q_in  in  8  DUT root output (final_op)
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  high in DONE; held until the next accepted start or rst
- error_count  out  17  number of samples with q_in ≠ floor(sqrt(R))
- ed_sum  out  24  sum of |ref − q_in| over all samples
- ed_max  out  8  maximum |ref − q_in|

## Operation
- **States and transitions**
  - States: IDLE, SWEEP, DRAIN, DONE.
  - IDLE or DONE: on start, clear the accumulators and the reference tracker, set R_out to 0, then go to SWEEP.
  - SWEEP: R_out increments by 1 per clock. After R_out = 65535 has been driven for one cycle, go to DRAIN.
  - DRAIN: wait until the last sample is consumed. DRAIN lasts DUT_LAT+1 cycles, then go to DONE.
- **Reference root tracking**
  - Registers: s (8 bits) and nsq (17 bits), with nsq = (s+1)².
  - Reset values: s = 0, nsq = 1.
  - When the radicand now being driven equals nsq: s becomes s+1 and nsq becomes nsq + 2s + 3, computed by shift and add.
  - The reference for radicand r is therefore floor(sqrt(r)). It reaches 255 at r = 65025 and stays there; nsq = 65536 is never matched.
- **Alignment with the DUT**
  - Each reference value and a valid bit pass through a DUT_LAT-stage delay line, so they arrive together with q_in for the same r.
- **Per-sample arithmetic**
  - ed = |ref − q_in|, 8 bits, unsigned, computed as the larger operand minus the smaller.
  - error_count increments when ed ≠ 0.
  - ed_sum accumulates ed.
  - ed_max is replaced when ed > ed_max.
  - Maximum values: error_count 65536, ed_sum 16,711,680. Neither wraps.
- **Start and reset conditions**
  - start during SWEEP or DRAIN is ignored. It does not restart the sweep or clear the counters.
  - start in DONE launches a new sweep from zeroed counters.
  - rst at any time, including mid-sweep, aborts the run: state goes to IDLE, R_out = 0, all outputs go to 0, and the delay line is invalidated.
- **Output values by state**
  - Outputs change during SWEEP and DRAIN.
  - They are final and stable in DONE.
  - After reset they are 0.

## Timing
- **Reset values:** R_out = 0, busy = 0, done = 0, error_count = 0, ed_sum = 0, ed_max = 0.
- **Sweep timing**
  - Let E0 be the edge that samples start.
  - R_out takes value r after edge E0+1+r, for r = 0..65535.
  - q_in for r is consumed at edge E0+2+r+DUT_LAT.
- **Status signal timing**
  - busy rises after edge E0+1.
  - busy falls and done rises after edge E0+65537+DUT_LAT.
  - The accumulators hold their final values from that same edge.
- **Sweep length:** total run is 65537 + DUT_LAT clocks from start to done.
- **Restart:** done falls on the edge that accepts a new start.

## Test plan
- **Exact DUT (floor sqrt model), DUT_LAT = 0:** start → error_count = 0, ed_sum = 0, ed_max = 0; done asserted exactly 65537 clocks after the start edge.
- **Constant q_in = 0:** error_count = 65535, ed_sum = 11,152,000, ed_max = 255.
- **DUT = exact+1, saturating at 255:** error_count = 65025, ed_sum = 65025, ed_max = 1.
- **Exact DUT as a 3-stage registered pipeline, DUT_LAT = 3:** all counters = 0; done arrives 3 clocks later than the DUT_LAT = 0 case; a DUT_LAT-mismatched bench (DUT_LAT = 0 against the same 3-stage DUT) gives error_count > 0.
- **Abort and restart:** assert rst for one cycle at R_out = 1000 → next cycle state is IDLE, R_out = 0 and all counters are 0; a subsequent start with the constant-0 DUT reproduces the full constant-0 results.
- **start pulses during SWEEP and DRAIN:** no effect on the sweep, counters or done timing; a start in DONE clears the counters and restarts at R_out = 0.
